// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - Operation handshake and HI/LO bus of the multiply/divide unit
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Multi-cycle signed/unsigned multiply/divide with HI/LO registers
// Magnitudes are iterated one bit per cycle; signs are applied in a single FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 op_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic                 b_zero;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 launch;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_next;

  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  assign op_signed = bus.op[0];
  assign a_neg     = op_signed & bus.a[WIDTH-1];
  assign b_neg     = op_signed & bus.b[WIDTH-1];
  assign b_zero    = (bus.b == '0);
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;
  assign launch    = bus.start & ~bus.abort;

  // Multiply: multiplier sits in the low half and shifts out LSB-first while
  // partial sums enter from the top; W+1 bits keep the carry of each add.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: {remainder, dividend/quotient} shifts left; a non-negative trial
  // commits the subtraction and shifts a 1 into the quotient.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign fix_hi   = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (launch) begin
          state_d   = S_RUN;
          cnt_d     = CNT_W'(WIDTH);
          is_div_d  = bus.op[1];
          // A zero divisor must leave the quotient all ones, so no negation.
          neg_res_d = (a_neg ^ b_neg) & ~(bus.op[1] & b_zero);
          neg_rem_d = a_neg;
          opb_d     = b_mag;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.abort) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - Self-checking bench for muldiv_unit (32-bit and 8-bit instances)
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus32 ();
  muldiv_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  muldiv_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {hi,lo} from plain integer arithmetic on w-bit operands.
  function automatic logic [63:0] ref_result(input int w, input logic [1:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ua, ub, p, qv, rv, hi_v, lo_v;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = (op[0] && ua[w-1]) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = (op[0] && ub[w-1]) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    if (!op[1]) begin
      p    = sa * sb;
      hi_v = (p >> w) & mask;
      lo_v = p & mask;
    end else if (ub == 64'd0) begin
      lo_v = mask;
      hi_v = ua;
    end else begin
      qv   = sa / sb;
      rv   = sa % sb;
      lo_v = qv & mask;
      hi_v = rv & mask;
    end
    return (hi_v << 32) | lo_v;
  endfunction

  // Starts at posedge+1, returns at posedge+1 one cycle after done.
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    logic [63:0] exp;
    int n, busy_n;
    bit got;
    exp = ref_result(32, op, a, b);
    bus32.start = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    n = 0; busy_n = bus32.busy ? 1 : 0; got = 1'b0;
    while (!got && n < 100) begin
      if (poke && n == 5) begin
        bus32.start = 1'b1; bus32.op = 2'b10; bus32.a = 32'd99; bus32.b = 32'd3;
        bus32.hi_we = 1'b1; bus32.wdata = 32'hDEAD_BEEF;
      end else if (poke && n == 6) begin
        bus32.start = 1'b0; bus32.hi_we = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (bus32.done) got = 1'b1;
      else if (bus32.busy) busy_n++;
    end
    chk("done_latency32", n, 33);
    chk("busy_cycles32", busy_n, 33);
    chk("busy_end32", bus32.busy, 1'b0);
    chk("hi32", bus32.hi, exp[63:32]);
    chk("lo32", bus32.lo, exp[31:0]);
    @(posedge clk); #1;
    chk("done_pulse32", bus32.done, 1'b0);
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [63:0] exp;
    int n;
    bit got;
    exp = ref_result(8, op, {24'd0, a}, {24'd0, b});
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (bus8.done) got = 1'b1;
    end
    chk("done_latency8", n, 9);
    chk("hi8", bus8.hi, exp[39:32]);
    chk("lo8", bus8.lo, exp[7:0]);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          n;
    bit          seen;

    bus32.start = 0; bus32.op = 0; bus32.a = 0; bus32.b = 0; bus32.abort = 0;
    bus32.hi_we = 0; bus32.lo_we = 0; bus32.wdata = 0;
    bus8.start = 0; bus8.op = 0; bus8.a = 0; bus8.b = 0; bus8.abort = 0;
    bus8.hi_we = 0; bus8.lo_we = 0; bus8.wdata = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus32.busy, 1'b0);
    chk("rst_done", bus32.done, 1'b0);
    chk("rst_hi", bus32.hi, 32'd0);
    chk("rst_lo", bus32.lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run32(2'b00, 32'h1e, 32'h1f, 1'b0);
    chk("multu_lit_lo", bus32.lo, 32'h0000_03a2);
    run32(2'b01, -32'sd3, 32'd5, 1'b0);
    chk("mult_lit_hi", bus32.hi, 32'hFFFF_FFFF);
    run32(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run32(2'b10, 32'd100, 32'd7, 1'b0);
    run32(2'b11, -32'sd7, 32'd2, 1'b0);
    chk("div_lit_lo", bus32.lo, 32'hFFFF_FFFD);
    run32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lit_lo", bus32.lo, 32'h8000_0000);
    run32(2'b10, 32'h1234, 32'd0, 1'b0);
    chk("divu0_lit_hi", bus32.hi, 32'h1234);
    run32(2'b11, -32'sd5, 32'd0, 1'b0);

    bus32.lo_we = 1'b1; bus32.wdata = 32'h55;
    @(posedge clk); #1;
    bus32.lo_we = 1'b0; bus32.hi_we = 1'b1; bus32.wdata = 32'hAA;
    @(posedge clk); #1;
    bus32.hi_we = 1'b0;
    chk("mthi", bus32.hi, 32'hAA);
    chk("mtlo", bus32.lo, 32'h55);

    run32(2'b00, 32'd6, 32'd7, 1'b1);
    chk("poke_lo", bus32.lo, 32'd42);

    bus32.start = 1'b1; bus32.op = 2'b10; bus32.a = 32'd9; bus32.b = 32'd3;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus32.abort = 1'b1;
    @(posedge clk); #1;
    bus32.abort = 1'b0;
    chk("abort_busy", bus32.busy, 1'b0);
    chk("abort_hi", bus32.hi, 32'd0);
    chk("abort_lo", bus32.lo, 32'd42);
    seen = bus32.done;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus32.done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);
    chk("abort_lo_kept", bus32.lo, 32'd42);

    bus32.start = 1'b1; bus32.abort = 1'b1; bus32.op = 2'b00; bus32.a = 32'd3; bus32.b = 32'd3;
    @(posedge clk); #1;
    bus32.start = 1'b0; bus32.abort = 1'b0;
    chk("start_abort_busy", bus32.busy, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus32.done) seen = 1'b1;
    end
    chk("start_abort_no_done", seen, 1'b0);

    bus32.start = 1'b1; bus32.op = 2'b00; bus32.a = 32'd2; bus32.b = 32'd3;
    bus32.hi_we = 1'b1; bus32.wdata = 32'h77;
    @(posedge clk); #1;
    bus32.start = 1'b0; bus32.hi_we = 1'b0;
    chk("wr_start_busy", bus32.busy, 1'b1);
    chk("wr_start_hi", bus32.hi, 32'h77);
    n = 0;
    while (!bus32.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wr_start_latency", n, 33);
    chk("wr_start_res_hi", bus32.hi, 32'd0);
    chk("wr_start_res_lo", bus32.lo, 32'd6);

    bus32.start = 1'b1; bus32.op = 2'b00; bus32.a = 32'd5; bus32.b = 32'd5;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_busy", bus32.busy, 1'b0);
    chk("async_rst_hi", bus32.hi, 32'd0);
    chk("async_rst_lo", bus32.lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    repeat (20) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      run32(rop, ra, rb, 1'b0);
    end

    run8(2'b00, 8'hFF, 8'hFF);
    chk("w8_lit_hi", bus8.hi, 8'hFE);
    chk("w8_lit_lo", bus8.lo, 8'h01);
    repeat (8) begin
      rop = 2'($urandom_range(0, 3));
      run8(rop, 8'($urandom), 8'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Replaces the single-cycle multu-only HI/LO path.
- Adds signed/unsigned multiply, signed/unsigned divide, and direct HI/LO writes (mthi/mtlo).
- Provides a busy/done handshake so the controller can stall mfhi/mflo until the result is ready.

Parameters:
- WIDTH, 32, operand width and HI/LO register width; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (unit is reset while reset==0).
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 multu, 01 mult, 10 divu, 11 div.
- a  input  WIDTH  multiplicand / dividend (rs).
- b  input  WIDTH  multiplier / divisor (rt).
- abort  input  1  cancel an in-flight operation (pipeline flush).
- hi_we  input  1  mthi write enable.
- lo_we  input  1  mtlo write enable.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - If start==1 at a rising edge: latch op.
  - Latch |a| and |b| when op is signed, otherwise a and b raw.
  - Record sign flags; counter=WIDTH; go to RUN; busy=1 from this edge.
- RUN:
  - One bit per clock.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Counter decrements each edge; after WIDTH edges go to FIX.
- FIX (one edge):
  - Apply sign correction and write hi/lo.
  - done=1 for exactly the following cycle; busy=0 from the same edge; return to IDLE.
- Latency: start edge E0; hi/lo valid and done=1 after edge E0+WIDTH+1.
  - busy is high for exactly WIDTH+1 cycles.
- Multiply results: {hi,lo} = full 2*WIDTH product.
  - mult: the product is negated when sign(a)^sign(b).
- Divide results: lo = quotient, hi = remainder.
  - Signed quotient sign = sign(a)^sign(b); remainder takes the sign of a.
  - Truncation toward zero.
- Divide by zero (b==0), both div and divu: lo = all ones, hi = a (original value). Still takes the full WIDTH+1 cycles.
- Signed overflow (a = most negative, b = −1): lo = most negative, hi = 0. Falls out of magnitude arithmetic; no special path.
- start while busy: ignored, no queuing.
- start and abort in the same IDLE cycle: abort wins; nothing launched.
- abort while in RUN or FIX:
  - Return to IDLE on the next edge; busy=0; done stays 0.
  - hi/lo keep their pre-start values.
- hi_we/lo_we:
  - Honoured only in IDLE: register ← wdata on the edge.
  - Both may be asserted together.
  - Ignored while busy.
  - In IDLE with start==1 in the same cycle, the write still happens and the operation launches; the later result overwrites the written value.
- hi/lo change only on reset, an IDLE write, or the FIX edge.
- done never asserts without a preceding completed operation.

Test Plan:
- multu, a=0x1e, b=0x1f → after 33 edges: done pulse, lo=0x000003a2, hi=0; busy high 33 cycles.
- mult, a=−3, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- mult, a=b=0x80000000 → hi=0x40000000, lo=0.
- divu, a=100, b=7 → lo=14, hi=2.
- div, a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div, a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- divu, a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- Control flow sequence:
  - Preload mtlo 0x55 and mthi 0xAA.
  - Start multu 6×7; mid-run pulse start (ignored) and hi_we (ignored); check hi=0, lo=42.
  - Then start divu 9/3 and abort after 10 cycles → hi=0, lo=42, no done.
  - Finally deassert reset mid-run → hi=lo=0, busy=0 asynchronously.
- WIDTH=8 instance: multu a=0xFF, b=0xFF → hi=0xFE, lo=0x01, done after 9 edges.
